chunk_serial_comparator: RTL and testbench

- Parametrised, multi-cycle successor to the 3-bit combinational magnitude comparator.
- Compares two WIDTH-bit operands CHUNK bits per clock, most-significant chunk first, and stops at the first chunk that differs.
- Produces the same six relational flags (eq, neq, lt, gt, le, ge) behind a start/busy/done handshake.
- Sits in the datapath wherever wide compares must be traded for fewer gates per cycle.

---
 rtl/chunk_serial_comparator.sv | 110 +++++++++++
 tb/tb_chunk_serial_comparator.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/chunk_serial_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per clock, MSB chunk first.
// Define COMPARATOR_SIGNED_EN to treat the operands as two's complement.
module chunk_serial_comparator #(
  parameter int WIDTH = 12,
  parameter int CHUNK = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             neq,
  output logic             lt,
  output logic             gt,
  output logic             le,
  output logic             ge
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE, CMP} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             done_q, done_d;
  logic [5:0]       flags_q, flags_d;
  logic [CHUNK-1:0] ca, cb;

  // The compare is in flight exactly while the FSM sits in CMP
  assign busy = (state_q == CMP);
  assign done = done_q;
  assign {eq, neq, lt, gt, le, ge} = flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
      flags_q <= flags_d;
    end
  end

  // Select the current chunk; in signed mode flipping the sign bit of the top
  // chunk maps two's complement order onto unsigned order.
  always_comb begin
    ca = '0;
    cb = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx_q == IW'(i)) begin
        ca = a_q[i*CHUNK +: CHUNK];
        cb = b_q[i*CHUNK +: CHUNK];
      end
    end
`ifdef COMPARATOR_SIGNED_EN
    if (idx_q == IW'(NCH - 1)) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IW'(NCH - 1);
          state_d = CMP;
        end
      end
      CMP: begin
        if (ca != cb) begin
          // {eq, neq, lt, gt, le, ge}
          flags_d = (ca > cb) ? 6'b010101 : 6'b011010;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == '0) begin
          flags_d = 6'b100011;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_chunk_serial_comparator.sv
// Self-checking bench for chunk_serial_comparator: directed vectors, handshake
// and reset corner cases, then a randomized run against a behavioural model.
module tb_chunk_serial_comparator;

  localparam int W = 12;
  localparam int C = 3;
  localparam int N = W / C;

  localparam logic [5:0] F_EQ = 6'b100011;
  localparam logic [5:0] F_LT = 6'b011010;
  localparam logic [5:0] F_GT = 6'b010101;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, eq, neq, lt, gt, le, ge;
  logic [5:0]   flags;
  logic [5:0]   lastFlags;
  int           checks = 0;
  int           failures = 0;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [5:0]   f;
    int           lat;
  } vec_t;

  vec_t vecs[6];

  chunk_serial_comparator #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .eq(eq), .neq(neq),
    .lt(lt), .gt(gt), .le(le), .ge(ge)
  );

  assign flags = {eq, neq, lt, gt, le, ge};

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference relation computed on whole operands
  function automatic logic [5:0] refFlags(input logic [W-1:0] x, input logic [W-1:0] y);
    logic e, l, g;
    e = (x == y);
`ifdef COMPARATOR_SIGNED_EN
    l = ($signed(x) < $signed(y));
`else
    l = (x < y);
`endif
    g = !e && !l;
    return {e, !e, l, g, l | e, g | e};
  endfunction

  // Number of chunks examined: position of first differing chunk from the MSB, plus one
  function automatic int refLat(input logic [W-1:0] x, input logic [W-1:0] y);
    int xi, yi;
    xi = int'(x);
    yi = int'(y);
    for (int i = N - 1; i >= 0; i--) begin
      if (((xi >> (i * C)) % (1 << C)) != ((yi >> (i * C)) % (1 << C))) return N - i;
    end
    return N;
  endfunction

  // Called on a negedge; returns on the negedge where done is visible
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic [5:0] expF, input int expLat,
                               input bit pulseMid, input string tag);
    int m;
    int drops;
    a = ta;
    b = tb;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    m = 0;
    drops = 0;
    checkOutput({tag, "_busy_accept"}, 32'(busy), 32'd1);
    checkOutput({tag, "_flags_held"}, 32'(flags), 32'(lastFlags));
    while (!done && m < 4 * N + 4) begin
      if (!busy) drops++;
      a = W'($urandom);
      b = W'($urandom);
      start = pulseMid && (m == 1);
      @(negedge clk);
      m++;
    end
    start = 1'b0;
    checkOutput({tag, "_done_seen"}, 32'(done), 32'd1);
    checkOutput({tag, "_latency"}, 32'(m), 32'(expLat));
    checkOutput({tag, "_busy_during"}, 32'(drops), 32'd0);
    checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    checkOutput({tag, "_flags"}, 32'(flags), 32'(expF));
    lastFlags = expF;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int mode, gap;

    vecs[0] = '{12'h5A3, 12'h5A3, F_EQ, 4};
`ifdef COMPARATOR_SIGNED_EN
    vecs[1] = '{12'h800, 12'h7FF, F_LT, 1};
    vecs[4] = '{12'h000, 12'hFFF, F_GT, 1};
`else
    vecs[1] = '{12'h800, 12'h7FF, F_GT, 1};
    vecs[4] = '{12'h000, 12'hFFF, F_LT, 1};
`endif
    vecs[2] = '{12'h123, 12'h124, F_LT, 4};
    vecs[3] = '{12'h124, 12'h123, F_GT, 4};
    vecs[5] = '{12'hFFF, 12'hFFE, F_GT, 4};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    lastFlags = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", 32'({busy, done, flags}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      applyStimulus(vecs[i].va, vecs[i].vb, vecs[i].f, vecs[i].lat, 1'b0, $sformatf("vec%0d", i));

    // Mid-compare start must be ignored; operands are scrambled while busy
    applyStimulus(12'h123, 12'h124, F_LT, 4, 1'b1, "ignore_start");
    // Start in the done cycle is accepted immediately
    applyStimulus(12'h124, 12'h123, F_GT, 4, 1'b0, "back_to_back");

    // Asynchronous reset in the middle of a compare
    a = 12'h5A3;
    b = 12'h5A3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 32'({busy, done, flags}), 32'd0);
    @(negedge clk);
    checkOutput("reset_held", 32'({busy, done, flags}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_idle", 32'({busy, done, flags}), 32'd0);
    lastFlags = '0;
    applyStimulus(12'h123, 12'h124, F_LT, 4, 1'b0, "after_reset");

    for (int n = 0; n < 2000; n++) begin
      ra = W'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 0) rb = W'($urandom);
      else if (mode == 1) rb = ra;
      else rb = ra ^ (W'($urandom_range(1, (1 << C) - 1)) << (C * $urandom_range(0, N - 1)));
      gap = $urandom_range(0, 2);
      start = 1'b0;
      repeat (gap) @(negedge clk);
      applyStimulus(ra, rb, refFlags(ra, rb), refLat(ra, rb), 1'b0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
